act_zero_run_compressor: RTL and testbench

Upstream feeder for one PE's activation FIFO. It accepts a raw activation stream and run-length-encodes zeros into compressed tokens of activation_width+1 bits, writing them straight into the PE AFIFO under its full flag. Flag bit 0 marks a non-zero activation value. Flag bit 1 marks a zero-run count, which lets the PE skip zero MACs.

---
 rtl/act_zero_run_compressor_pkg.sv | 26 ++
 rtl/act_token_out_reg.sv | 52 +++++
 rtl/act_zero_run_compressor.sv | 142 ++++++++++++++
 tb/tb_act_zero_run_compressor.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_zero_run_compressor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : act_zero_run_compressor_pkg
// Description : Shared definitions for the activation zero-run compressor.
//               Holds the token flag values, the token-width helper and the
//               compressor state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package act_zero_run_compressor_pkg;

  // Token MSB: 0 = literal activation value, 1 = zero-run count
  localparam logic FLAG_VAL = 1'b0;
  localparam logic FLAG_RUN = 1'b1;

  // A token is the activation/run field plus one flag bit
  function automatic int compressed_width(input int act_width);
    return act_width + 1;
  endfunction

  typedef enum logic [0:0] {
    S_PASS = 1'b0,
    S_HOLD = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/act_token_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : act_token_out_reg
// Description : Single-entry output register feeding a FIFO write port.
//               A held token is written whenever the FIFO is not full; a new
//               token may load in the same edge as a write (1 token/cycle).
// Ports       : clk, rst_n      - clock, async active-low reset
//               load, load_data, load_last - new token (only when free)
//               afifo_full     - downstream FIFO full flag
//               data, last     - registered token and its end-of-row flag
//               write          - FIFO write strobe
//               free           - register can accept a token this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module act_token_out_reg #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             afifo_full,
  output logic [WIDTH-1:0] data,
  output logic             last,
  output logic             write,
  output logic             free
);

  logic vld;

  assign write = vld & ~afifo_full;
  assign free  = ~vld | write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      data <= '0;
      last <= 1'b0;
    end else if (load) begin
      // A load in the same edge as a write replaces the written token
      vld  <= 1'b1;
      data <= load_data;
      last <= load_last;
    end else if (write) begin
      vld  <= 1'b0;
      last <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/act_zero_run_compressor.sv
`default_nettype none
// ============================================================================
// Module      : act_zero_run_compressor
// Description : Run-length encodes zeros of a raw activation stream into
//               flag-tagged tokens written into a PE activation FIFO.
//               {0,value} = non-zero activation, {1,count} = run of zeros
//               (count 1..MAX_RUN). Runs always flush at a row end.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               act_in/act_valid/act_last  - raw activation stream
//               act_ready                  - input accepted this cycle
//               compressed_act_out         - token to AFIFO DataIn
//               AFIFO_write / AFIFO_full   - AFIFO write strobe / full flag
//               row_done                   - last token of a row written
//               zero_cnt                   - saturating accepted-zero count
// Revision    : 1.0 - initial release
// ============================================================================
module act_zero_run_compressor
  import act_zero_run_compressor_pkg::*;
#(
  parameter int activation_width     = 16,
  parameter int compressed_act_width = compressed_width(activation_width),
  parameter int MAX_RUN              = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [activation_width-1:0]     act_in,
  input  logic                            act_valid,
  input  logic                            act_last,
  output logic                            act_ready,
  output logic [compressed_act_width-1:0] compressed_act_out,
  output logic                            AFIFO_write,
  input  logic                            AFIFO_full,
  output logic                            row_done,
  output logic [15:0]                     zero_cnt
);

  localparam logic [activation_width-1:0] MAX_RUN_W = activation_width'(MAX_RUN);
  localparam logic [activation_width-1:0] ONE_W     = activation_width'(1);

  state_t                            state;
  logic [activation_width-1:0]       run;
  logic [activation_width-1:0]       run_inc;
  logic [activation_width-1:0]       hold_val;
  logic                              hold_last;

  logic                              free;
  logic                              o_last;
  logic                              load;
  logic [compressed_act_width-1:0]   load_data;
  logic                              load_last;
  logic                              accept;
  logic                              is_zero;
  logic                              run_flush;

  // Gated by rst_n so the producer never sees ready while reset is held
  assign act_ready = rst_n & (state == S_PASS) & free;
  assign accept    = act_valid & act_ready;
  assign is_zero   = (act_in == '0);
  assign run_inc   = run + ONE_W;
  assign run_flush = (run_inc == MAX_RUN_W) | act_last;
  assign row_done  = AFIFO_write & o_last;

  // Token selection. A held value always goes out before new input, since
  // act_ready is low in S_HOLD.
  always_comb begin
    load      = 1'b0;
    load_data = '0;
    load_last = 1'b0;
    if (state == S_HOLD) begin
      if (free) begin
        load      = 1'b1;
        load_data = {FLAG_VAL, hold_val};
        load_last = hold_last;
      end
    end else if (accept) begin
      if (!is_zero) begin
        load = 1'b1;
        if (run == '0) begin
          load_data = {FLAG_VAL, act_in};
          load_last = act_last;
        end else begin
          // Pending run goes first; the value waits in the hold register
          load_data = {FLAG_RUN, run};
          load_last = 1'b0;
        end
      end else if (run_flush) begin
        load      = 1'b1;
        load_data = {FLAG_RUN, run_inc};
        load_last = act_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_PASS;
      run       <= '0;
      hold_val  <= '0;
      hold_last <= 1'b0;
      zero_cnt  <= '0;
    end else begin
      if (state == S_HOLD) begin
        if (free) begin
          state <= S_PASS;
        end
      end else if (accept) begin
        if (!is_zero) begin
          if (run != '0) begin
            hold_val  <= act_in;
            hold_last <= act_last;
            state     <= S_HOLD;
          end
          run <= '0;
        end else if (run_flush) begin
          run <= '0;
        end else begin
          run <= run_inc;
        end
        if (is_zero && (zero_cnt != 16'hFFFF)) begin
          zero_cnt <= zero_cnt + 16'd1;
        end
      end
    end
  end

  act_token_out_reg #(
    .WIDTH (compressed_act_width)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_data  (load_data),
    .load_last  (load_last),
    .afifo_full (AFIFO_full),
    .data       (compressed_act_out),
    .last       (o_last),
    .write      (AFIFO_write),
    .free       (free)
  );

endmodule
`default_nettype wire

// File: tb/tb_act_zero_run_compressor.sv
`default_nettype none
// ============================================================================
// Module      : tb_act_zero_run_compressor
// Description : Self-checking bench for act_zero_run_compressor: per-element
//               vector table, cycle-exact directed sequences, and a random
//               stream checked against a stream-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_act_zero_run_compressor;

  localparam int AW      = 16;
  localparam int MAX_RUN = 255;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] act_in;
  logic          act_valid;
  logic          act_last;
  logic          act_ready;
  logic [AW:0]   compressed_act_out;
  logic          AFIFO_write;
  logic          AFIFO_full;
  logic          row_done;
  logic [15:0]   zero_cnt;

  act_zero_run_compressor #(
    .activation_width     (AW),
    .compressed_act_width (AW + 1),
    .MAX_RUN              (MAX_RUN)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .act_in             (act_in),
    .act_valid          (act_valid),
    .act_last           (act_last),
    .act_ready          (act_ready),
    .compressed_act_out (compressed_act_out),
    .AFIFO_write        (AFIFO_write),
    .AFIFO_full         (AFIFO_full),
    .row_done           (row_done),
    .zero_cnt           (zero_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Recorded/expected write: {row_done, flag, field}
  typedef logic [AW+1:0] tok_t;
  typedef tok_t tok_q_t[$];
  typedef struct {
    logic [AW-1:0] v;
    logic          l;
  } elem_t;
  typedef elem_t elem_q_t[$];

  typedef struct {
    logic [AW-1:0] a;
    logic          l;
    int            n;
    tok_t          t0;
    tok_t          t1;
  } vec_t;

  int      n_cmp = 0;
  int      n_err = 0;
  int      exp_zeros = 0;
  bit      rnd_full = 1'b0;
  tok_q_t  got;
  elem_q_t sent;

  always @(negedge clk) begin
    if (AFIFO_write) got.push_back({row_done, compressed_act_out});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic tok_t mk(input logic rd, input logic flag, input int f);
    return {rd, flag, AW'(f)};
  endfunction

  // Stream-level reference: zeros accumulate until a non-zero, the MAX_RUN
  // cap or a row end; a non-zero flushes any run before its own token.
  function automatic tok_q_t model(input elem_q_t s);
    tok_q_t q;
    int     run = 0;
    foreach (s[i]) begin
      if (s[i].v == 0) begin
        run++;
        if (run == MAX_RUN || s[i].l) begin
          q.push_back(mk(s[i].l, 1'b1, run));
          run = 0;
        end
      end else begin
        if (run > 0) q.push_back(mk(1'b0, 1'b1, run));
        q.push_back(mk(s[i].l, 1'b0, int'(s[i].v)));
        run = 0;
      end
    end
    return q;
  endfunction

  task automatic compare_q(input string nm, input tok_q_t exp);
    chk({nm, "_count"}, got.size(), exp.size());
    if (got.size() == exp.size()) begin
      foreach (exp[i]) chk({nm, "_token"}, got[i], exp[i]);
    end
  endtask

  task automatic note_accept(input logic [AW-1:0] v, input logic l);
    elem_t e;
    e.v = v;
    e.l = l;
    sent.push_back(e);
    if (v == 0 && exp_zeros != 65535) exp_zeros++;
  endtask

  task automatic send(input logic [AW-1:0] v, input logic l);
    int  guard = 0;
    bit  done  = 1'b0;
    act_valid = 1'b1;
    act_in    = v;
    act_last  = l;
    while (!done) begin
      @(negedge clk);
      if (act_ready) begin
        done = 1'b1;
      end else if (guard > 1000) begin
        chk("send_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      guard++;
      if (rnd_full) AFIFO_full = ($urandom_range(0, 2) == 0);
    end
    if (guard <= 1001) note_accept(v, l);
    act_valid = 1'b0;
    act_in    = '0;
    act_last  = 1'b0;
  endtask

  task automatic drain();
    AFIFO_full = 1'b0;
    act_valid  = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  vec_t         tbl[12];
  logic [AW-1:0] t1_in[4];
  int           t1_rdy[6];
  int           t1_wr[6];
  int           t1_tok[6];
  int           t1_rd[6];
  tok_q_t       exp_q;
  int           idx;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // {act_in, act_last, tokens produced, token0, token1}
    tbl[0]  = '{16'd5, 1'b0, 1, mk(0, 0, 5), '0};
    tbl[1]  = '{16'd0, 1'b0, 0, '0, '0};
    tbl[2]  = '{16'd0, 1'b0, 0, '0, '0};
    tbl[3]  = '{16'd7, 1'b1, 2, mk(0, 1, 2), mk(1, 0, 7)};
    tbl[4]  = '{16'd0, 1'b0, 0, '0, '0};
    tbl[5]  = '{16'd0, 1'b0, 0, '0, '0};
    tbl[6]  = '{16'd0, 1'b1, 1, mk(1, 1, 3), '0};
    tbl[7]  = '{16'd4, 1'b1, 1, mk(1, 0, 4), '0};
    tbl[8]  = '{16'd0, 1'b1, 1, mk(1, 1, 1), '0};
    tbl[9]  = '{16'd0, 1'b0, 0, '0, '0};
    tbl[10] = '{16'hFFFF, 1'b0, 2, mk(0, 1, 1), mk(0, 0, 16'hFFFF)};
    tbl[11] = '{16'd0, 1'b1, 1, mk(1, 1, 1), '0};

    t1_in  = '{16'd5, 16'd0, 16'd0, 16'd7};
    t1_rdy = '{1, 1, 1, 1, 0, 1};
    t1_wr  = '{0, 1, 0, 0, 1, 1};
    t1_tok = '{0, 32'h00005, 0, 0, 32'h10002, 32'h00007};
    t1_rd  = '{0, 0, 0, 0, 0, 1};

    rst_n      = 1'b0;
    act_in     = '0;
    act_valid  = 1'b0;
    act_last   = 1'b0;
    AFIFO_full = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", act_ready, 0);
    chk("reset_write", AFIFO_write, 0);
    chk("reset_data", compressed_act_out, 0);
    chk("reset_row_done", row_done, 0);
    chk("reset_zero_cnt", zero_cnt, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Per-element table
    for (int i = 0; i < 12; i++) begin
      got.delete();
      send(tbl[i].a, tbl[i].l);
      drain();
      chk("tbl_count", got.size(), tbl[i].n);
      if (got.size() == tbl[i].n && tbl[i].n > 0) chk("tbl_tok0", got[0], tbl[i].t0);
      if (got.size() == tbl[i].n && tbl[i].n > 1) chk("tbl_tok1", got[1], tbl[i].t1);
    end
    chk("tbl_zero_cnt", zero_cnt, exp_zeros);

    // Row 5,0,0,7 with valid held: cycle-exact ready and write pattern
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      if (idx < 4) begin
        act_valid = 1'b1;
        act_in    = t1_in[idx];
        act_last  = (idx == 3);
      end else begin
        act_valid = 1'b0;
        act_in    = '0;
        act_last  = 1'b0;
      end
      @(negedge clk);
      chk("t1_ready", act_ready, t1_rdy[c]);
      chk("t1_write", AFIFO_write, t1_wr[c]);
      if (t1_wr[c] != 0) begin
        chk("t1_token", compressed_act_out, t1_tok[c]);
        chk("t1_row_done", row_done, t1_rd[c]);
      end
      if (act_valid && act_ready) begin
        note_accept(act_in, act_last);
        idx++;
      end
      @(posedge clk);
      #1;
    end
    drain();

    // 600 zeros then 3(last): cap splits the run
    got.delete();
    for (int i = 0; i < 600; i++) send(16'd0, 1'b0);
    send(16'd3, 1'b1);
    drain();
    exp_q = '{mk(0, 1, 255), mk(0, 1, 255), mk(0, 1, 90), mk(1, 0, 3)};
    compare_q("maxrun", exp_q);
    chk("maxrun_zero_cnt", zero_cnt, exp_zeros);

    // Stall: token held stable while full, written once when full drops
    got.delete();
    AFIFO_full = 1'b1;
    send(16'd6, 1'b1);
    act_valid = 1'b1;
    act_in    = 16'd8;
    act_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_write", AFIFO_write, 0);
      chk("stall_data", compressed_act_out, 32'h00006);
      chk("stall_ready", act_ready, 0);
      @(posedge clk);
      #1;
    end
    AFIFO_full = 1'b0;
    @(negedge clk);
    chk("unstall_write", AFIFO_write, 1);
    chk("unstall_row_done", row_done, 1);
    chk("unstall_ready", act_ready, 1);
    if (act_ready) note_accept(act_in, act_last);
    @(posedge clk);
    #1;
    drain();
    exp_q = '{mk(1, 0, 6), mk(1, 0, 8)};
    compare_q("stall", exp_q);

    // Back-to-back non-zeros 1..8: one write per cycle, one cycle after accept
    got.delete();
    for (int c = 0; c < 9; c++) begin
      act_valid = (c < 8);
      act_in    = (c < 8) ? AW'(c + 1) : '0;
      act_last  = (c == 7);
      @(negedge clk);
      if (c < 8) chk("b2b_ready", act_ready, 1);
      chk("b2b_write", AFIFO_write, (c >= 1));
      if (c >= 1) chk("b2b_token", compressed_act_out, c);
      if (act_valid && act_ready) note_accept(act_in, act_last);
      @(posedge clk);
      #1;
    end
    drain();
    chk("b2b_total", got.size(), 8);

    // Async reset while holding value 9
    act_valid = 1'b1;
    act_in    = 16'd0;
    act_last  = 1'b0;
    @(posedge clk);
    #1;
    act_in = 16'd9;
    @(posedge clk);
    #1;
    act_valid = 1'b0;
    act_in    = '0;
    @(negedge clk);
    chk("hold_run_token", compressed_act_out, 32'h10001);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data", compressed_act_out, 0);
    chk("arst_write", AFIFO_write, 0);
    chk("arst_row_done", row_done, 0);
    chk("arst_zero_cnt", zero_cnt, 0);
    chk("arst_ready", act_ready, 0);
    exp_zeros = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    got.delete();
    @(posedge clk);
    #1;
    send(16'd2, 1'b1);
    drain();
    exp_q = '{mk(1, 0, 2)};
    compare_q("post_reset", exp_q);

    // Random rows with random FIFO back-pressure against the model
    got.delete();
    sent.delete();
    rnd_full = 1'b1;
    for (int r = 0; r < 30; r++) begin
      int len;
      len = $urandom_range(1, 20);
      for (int j = 0; j < len; j++) begin
        logic [AW-1:0] v;
        v = ($urandom_range(0, 9) < 6) ? '0 : AW'($urandom_range(1, 65535));
        send(v, (j == len - 1));
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
          AFIFO_full = ($urandom_range(0, 2) == 0);
        end
      end
    end
    rnd_full = 1'b0;
    drain();
    drain();
    compare_q("random", model(sent));
    chk("random_zero_cnt", zero_cnt, exp_zeros);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
